// File: rtl/spi_controller.sv
// SPI initiator: serialises one {wr_rdn, addr, data} register frame and returns read data.
// Ports: clk/rstb, ena, request (start, mode, wr_rdn, addr, wdata), status (rdata, busy, done), SPI pins.
module spi_controller #(
  parameter int ADDR_W  = 7,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_LEN = 1 + ADDR_W + REG_W;
  localparam int EDGES     = 2 * FRAME_LEN;
  localparam int BIT_W     = $clog2(EDGES + 1);
  localparam int DIV_W     = $clog2(CLK_DIV);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [FRAME_LEN-1:0] tx;
  logic [REG_W-1:0]     rx;
  logic                 cpol;
  logic                 cpha;
  logic                 wr_q;

  logic                 div_end;
  logic                 lead;
  logic                 last_edge;
  logic [FRAME_LEN-1:0] frame;

  always_comb begin
    div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    // even edge count means the next toggle is a leading edge
    lead      = ~bit_cnt[0];
    last_edge = (bit_cnt == BIT_W'(EDGES - 1));
    frame     = {wr_rdn, addr, (wr_rdn ? wdata : {REG_W{1'b0}})};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      wr_q     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      // done stays a single-cycle pulse even if ena drops
      done <= 1'b0;
      if (ena) begin
        unique case (1'b1)
          (state == IDLE): begin
            if (start) begin
              state    <= SETUP;
              cpol     <= mode[1];
              cpha     <= mode[0];
              wr_q     <= wr_rdn;
              busy     <= 1'b1;
              spi_cs_n <= 1'b0;
              spi_clk  <= mode[1];
              div_cnt  <= '0;
              bit_cnt  <= '0;
              // CPHA=0 presents the MSB before the first edge;
              // CPHA=1 drives it on the first (leading) edge
              if (mode[0]) begin
                spi_mosi <= 1'b0;
                tx       <= frame;
              end else begin
                spi_mosi <= frame[FRAME_LEN-1];
                tx       <= {frame[FRAME_LEN-2:0], 1'b0};
              end
            end
          end
          (state == SETUP): begin
            if (div_end) begin
              div_cnt <= '0;
              state   <= SHIFT;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          (state == SHIFT): begin
            if (div_end) begin
              div_cnt <= '0;
              spi_clk <= ~spi_clk;
              if (lead ^ cpha) begin
                rx <= {rx[REG_W-2:0], spi_miso};
              end else begin
                spi_mosi <= tx[FRAME_LEN-1];
                tx       <= {tx[FRAME_LEN-2:0], 1'b0};
              end
              if (last_edge) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          (state == HOLD): begin
            if (div_end) begin
              div_cnt  <= '0;
              state    <= GAP;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              done     <= 1'b1;
              if (!wr_q) rdata <= rx;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          (state == GAP): begin
            if (div_end) begin
              div_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a SPI responder model and a frame scoreboard.
// Checks latency, MOSI stream, read data, mode handling, pause, ignored starts and abort.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       start = 1'b0;
  logic       wr_rdn = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  spi_controller #(
    .ADDR_W(7),
    .REG_W(8),
    .CLK_DIV(4)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .ena(ena),
    .mode(mode),
    .start(start),
    .wr_rdn(wr_rdn),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ena_edge = 1'b1;

  logic [1:0]  cur_mode = 2'b00;
  logic [7:0]  miso_byte = '0;
  logic [7:0]  model_rdata = '0;
  logic [15:0] mosi_cap = '0;
  int rising = 0;
  int cs_falls = 0;
  int mosi_bad = 0;
  int pause_bad = 0;
  int done_cnt = 0;
  int k = 0;
  logic prev_clk = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_mosi = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ena_edge <= ena;
  end

  function automatic logic miso_bit(input int idx);
    logic [7:0] b;
    b = miso_byte;
    if (idx >= 8 && idx < 16) return b[3'(15 - idx)];
    return 1'b0;
  endfunction

  // responder + line monitor; DUT outputs only move on posedge
  always @(negedge clk) begin
    logic lead;
    logic chg;
    chg = (spi_clk !== prev_clk);
    if (prev_cs && !spi_cs_n) begin
      rising = 0;
      mosi_cap = '0;
      k = 0;
      cs_falls++;
      if (!cur_mode[0]) begin
        spi_miso = miso_bit(0);
        k = 1;
      end
    end else if (!prev_cs && !spi_cs_n) begin
      if ((chg || spi_mosi !== prev_mosi) && !ena_edge) pause_bad++;
      if (chg) begin
        lead = (spi_clk != cur_mode[1]);
        if (spi_clk) rising++;
        if (lead ^ cur_mode[0]) begin
          mosi_cap = {mosi_cap[14:0], spi_mosi};
          if (spi_mosi !== prev_mosi) mosi_bad++;
        end else begin
          spi_miso = miso_bit(k);
          k++;
        end
      end else if (spi_mosi !== prev_mosi) begin
        mosi_bad++;
      end
    end
    if (done) done_cnt++;
    prev_clk = spi_clk;
    prev_cs = spi_cs_n;
    prev_mosi = spi_mosi;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic wr,
                     input logic [6:0] a, input logic [7:0] wd,
                     input logic [7:0] mb, input bit pause,
                     input bit extra, input string tag);
    exp_t e;
    int t0;
    int f0;
    bit fin;
    int n;
    @(negedge clk);
    cur_mode = m;
    mode = m;
    wr_rdn = wr;
    addr = a;
    wdata = wd;
    miso_byte = mb;
    start = 1'b1;
    t0 = cyc;
    f0 = cs_falls;
    e.mosi = {wr, a, (wr ? wd : 8'h00)};
    e.rdata = wr ? model_rdata : mb;
    e.lat = pause ? 157 : 137;
    sb.push_back(e);
    if (!wr) model_rdata = mb;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      start = extra && (cyc - t0 == 50);
      mode = ~m;
      wr_rdn = ~wr;
      addr = ~a;
      wdata = ~wd;
      if (pause && cyc - t0 == 60) ena = 1'b0;
      if (pause && cyc - t0 == 80) ena = 1'b1;
      if (done) fin = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(fin), 32'd1);
    e = sb.pop_front();
    chk({tag, " done_lat"}, cyc - t0, e.lat);
    chk({tag, " rdata"}, 32'(rdata), 32'(e.rdata));
    chk({tag, " mosi"}, 32'(mosi_cap), 32'(e.mosi));
    chk({tag, " rising"}, rising, 16);
    chk({tag, " cs_n_at_done"}, 32'(spi_cs_n), 32'd1);
    @(negedge clk);
    start = extra;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_fall"}, cyc - t0, e.lat + 4);
    chk({tag, " cs_falls"}, cs_falls - f0, 1);
    chk({tag, " idle_clk"}, 32'(spi_clk), 32'(m[1]));
  endtask

  initial begin
    int t0;
    int d0;
    int f0;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst clk", 32'(spi_clk), 32'd0);
    chk("rst mosi", 32'(spi_mosi), 32'd0);
    chk("rst rdata", 32'(rdata), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    run(2'b00, 1'b1, 7'h05, 8'hA5, 8'h00, 1'b0, 1'b1, "m0_wr");
    run(2'b00, 1'b0, 7'h0A, 8'h00, 8'h3C, 1'b0, 1'b0, "m0_rd");
    run(2'b11, 1'b0, 7'h7F, 8'h00, 8'hC3, 1'b0, 1'b0, "m3_rd");
    run(2'b01, 1'b0, 7'h7F, 8'h00, 8'hC3, 1'b0, 1'b0, "m1_rd");
    run(2'b10, 1'b0, 7'h7F, 8'h00, 8'hC3, 1'b0, 1'b0, "m2_rd");
    run(2'b00, 1'b1, 7'h33, 8'h5A, 8'h00, 1'b1, 1'b0, "pause_wr");
    chk("pause quiet", pause_bad, 0);
    run(2'b01, 1'b0, 7'h11, 8'h00, 8'h96, 1'b0, 1'b0, "m1_rd2");

    // start while ena low must not launch a frame
    @(negedge clk);
    f0 = cs_falls;
    ena = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("ena0 start", cs_falls - f0, 0);
    chk("ena0 busy", 32'(busy), 32'd0);

    // abort a mode 2 write mid-frame
    @(negedge clk);
    cur_mode = 2'b10;
    mode = 2'b10;
    wr_rdn = 1'b1;
    addr = 7'h22;
    wdata = 8'hFF;
    start = 1'b1;
    t0 = cyc;
    e.mosi = 16'hA2FF;
    e.rdata = model_rdata;
    e.lat = 137;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 60) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("abort cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort clk", 32'(spi_clk), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rdata", 32'(rdata), 32'd0);
    e = sb.pop_front();
    model_rdata = '0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("abort no_done", done_cnt - d0, 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    run(2'b01, 1'b1, 7'h44, 8'h3C, 8'h00, 1'b0, 1'b0, "post_rst_wr");
    chk("mosi stable", mosi_bad, 0);
    chk("sb empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
